// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_TRAP = 2'd2,
        SRC_UART = 2'd3
    } src_e;

    localparam logic [4:0] K0_ADDR_DEF   = 5'd26;
    localparam logic [4:0] UART_REG0_DEF = 5'd24;
    localparam logic [4:0] UART_REG1_DEF = 5'd25;

    // Bit 8 is the destination flag, bits 7:0 the received byte.
    localparam int UART_ENTRY_W = 9;

    function automatic logic [31:0] uart_word(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO holding {flag, byte} UART entries until the write slot frees up.
module uart_byte_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [UART_ENTRY_W-1:0] push_data,
    input  logic                    pop,
    output logic [UART_ENTRY_W-1:0] pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [CW-1:0]           count
);

    logic [UART_ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           rd_ptr_r;
    logic [CW-1:0]           count_r;
    logic                    do_push_s;
    logic                    do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the single register-file write port between WB, trap ($k0) and UART mailbox writes,
// raising stall_req when a non-WB write has waited too long.
module regfile_wport_arbiter
    import rf_arb_pkg::*;
#(
    parameter int         UART_FIFO_DEPTH = 4,
    parameter int         STARVE_LIMIT    = 8,
    parameter logic [4:0] K0_ADDR         = K0_ADDR_DEF,
    parameter logic [4:0] UART_REG0       = UART_REG0_DEF,
    parameter logic [4:0] UART_REG1       = UART_REG1_DEF,
    localparam int        FCW             = $clog2(UART_FIFO_DEPTH + 1),
    localparam int        SCW             = $clog2(STARVE_LIMIT + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    input  logic            trap_valid,
    input  logic [31:0]     trap_data,
    output logic            trap_ready,
    input  logic            uart_valid,
    input  logic            uart_flag,
    input  logic [7:0]      uart_data,
    output logic            uart_ready,
    output logic            rf_we,
    output logic [4:0]      rf_addr,
    output logic [31:0]     rf_data,
    output logic            stall_req,
    output logic            err_drop,
    output logic [FCW-1:0]  fifo_count
);

    logic                    trap_pend_r;
    logic [31:0]             trap_data_r;
    logic [SCW-1:0]          starve_cnt_r;

    logic                    wb_req_s;
    logic                    trap_ready_s;
    logic                    trap_acc_s;
    logic                    uart_ready_s;
    logic                    uart_push_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [UART_ENTRY_W-1:0] fifo_head_s;
    logic [FCW-1:0]          fifo_count_s;
    logic                    nonwb_pend_s;
    src_e                    grant_s;
    logic [4:0]              grant_addr_s;
    logic [31:0]             grant_data_s;

    // Address 0 is hardwired, so a WB "write" to it never takes the slot.
    assign wb_req_s     = wb_we && (wb_addr != 5'd0);
    assign trap_ready_s = ~trap_pend_r;
    assign trap_acc_s   = trap_valid && trap_ready_s;
    assign uart_ready_s = ~fifo_full_s;
    assign uart_push_s  = uart_valid && uart_ready_s;
    assign nonwb_pend_s = trap_pend_r || (fifo_count_s != FCW'(0));

    assign trap_ready = trap_ready_s & ~reset;
    assign uart_ready = uart_ready_s & ~reset;
    assign fifo_count = fifo_count_s;
    assign stall_req  = trap_pend_r || (starve_cnt_r == SCW'(STARVE_LIMIT));

    uart_byte_fifo #(
        .DEPTH (UART_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (uart_push_s),
        .push_data ({uart_flag, uart_data}),
        .pop       (grant_s == SRC_UART),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Fixed-priority grant of this cycle's write slot and the write it carries.
    always_comb begin
        grant_s      = SRC_NONE;
        grant_addr_s = 5'd0;
        grant_data_s = 32'h0000_0000;
        if (wb_req_s) begin
            grant_s      = SRC_WB;
            grant_addr_s = wb_addr;
            grant_data_s = wb_data;
        end else if (trap_pend_r || trap_acc_s) begin
            grant_s      = SRC_TRAP;
            grant_addr_s = K0_ADDR;
            grant_data_s = trap_pend_r ? trap_data_r : trap_data;
        end else if (!fifo_empty_s) begin
            grant_s      = SRC_UART;
            grant_addr_s = fifo_head_s[8] ? UART_REG1 : UART_REG0;
            grant_data_s = uart_word(fifo_head_s[7:0]);
        end else begin
            grant_s      = SRC_NONE;
        end
    end

    // Registered write port, trap holding register, starvation counter and sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we        <= 1'b0;
            rf_addr      <= 5'd0;
            rf_data      <= 32'h0000_0000;
            trap_pend_r  <= 1'b0;
            trap_data_r  <= 32'h0000_0000;
            starve_cnt_r <= SCW'(0);
            err_drop     <= 1'b0;
        end else begin
            rf_we   <= (grant_s != SRC_NONE);
            rf_addr <= grant_addr_s;
            rf_data <= grant_data_s;

            if (grant_s == SRC_TRAP) begin
                trap_pend_r <= 1'b0;
            end else if (trap_acc_s) begin
                trap_pend_r <= 1'b1;
                trap_data_r <= trap_data;
            end

            if ((grant_s == SRC_TRAP) || (grant_s == SRC_UART) || !nonwb_pend_s) begin
                starve_cnt_r <= SCW'(0);
            end else if ((grant_s == SRC_WB) && (starve_cnt_r != SCW'(STARVE_LIMIT))) begin
                starve_cnt_r <= starve_cnt_r + SCW'(1);
            end

            if ((trap_valid && !trap_ready_s) || (uart_valid && !uart_ready_s)) begin
                err_drop <= 1'b1;
            end
        end
    end

endmodule
